// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter: two-requester round-robin arbiter in front of an immediate extender.
//
// A request is accepted in IDLE. The extended result is computed and registered in CALC.
// It is then held in RESP until rsp_ready is seen. Only one transaction is in flight at
// a time, so the best-case rate is one request every three cycles.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   req_valid[1:0]       request valid per requester (0 = decode, 1 = branch unit)
//   req_ready[1:0]       one-hot grant, combinational, only in IDLE
//   req_imm0/1, req_mode0/1
//                        immediate and mode per requester
//                        (0 sext, 1 zext, 2 upper-load, 3 branch)
//   rsp_valid/rsp_ready  response handshake
//   rsp_data, rsp_id     extended result and the id of the requester served
//   busy                 high whenever not IDLE
//
// Configuration: define IMM_SHIFT_MODES_EN to enable modes 2 and 3. Without it, both
// modes fold into mode 0 and no shifter is built.
module imm_ext_arbiter #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [IN_W-1:0]  req_imm0,
  input  logic [IN_W-1:0]  req_imm1,
  input  logic [1:0]       req_mode0,
  input  logic [1:0]       req_mode1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [OUT_W-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic [IN_W-1:0]  imm_q, imm_d;
  logic [1:0]       mode_q, mode_d;
  logic             id_q, id_d;
  logic [OUT_W-1:0] data_q, data_d;

  logic [1:0]       grant;
  logic [OUT_W-1:0] sext, zext, ext;

  // Round-robin only matters on a tie; a lone requester always wins.
  always_comb begin
    grant = 2'b00;
    unique case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Gated by rst so the grant is quiet for the whole reset window, not just after an edge.
  assign req_ready = (state_q == StIdle && !rst) ? grant : 2'b00;

  always_comb begin
    sext = {{(OUT_W-IN_W){imm_q[IN_W-1]}}, imm_q};
    zext = {{(OUT_W-IN_W){1'b0}}, imm_q};
    ext  = sext;
    case (mode_q)
      2'd1:    ext = zext;
`ifdef IMM_SHIFT_MODES_EN
      2'd2:    ext = zext << IN_W;
      2'd3:    ext = sext << 2;
`endif
      default: ext = sext;
    endcase
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    imm_d   = imm_q;
    mode_d  = mode_q;
    id_d    = id_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (|req_ready) begin
          imm_d   = req_ready[1] ? req_imm1 : req_imm0;
          mode_d  = req_ready[1] ? req_mode1 : req_mode0;
          id_d    = req_ready[1];
          state_d = StCalc;
        end
      end
      StCalc: begin
        data_d  = ext;
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          // Hand the next tie to whoever was not just served.
          prio_d  = ~id_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      imm_q   <= '0;
      mode_q  <= 2'd0;
      id_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      imm_q   <= imm_d;
      mode_q  <= mode_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != StIdle);

endmodule
